// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the three-way SDRAM word-port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2,
        OWN_DSK  = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]  WTBT_WORD = 2'b11;
    localparam logic [15:0] TMO_DATA  = 16'hFFFF;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational priority picker: video first, then disk over CPU unless the CPU is starved.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   vid_req,
    input  logic   dsk_req,
    input  logic   cpu_starved,
    output owner_t owner
);

    always_comb begin
        owner = OWN_NONE;
        if (vid_req) begin
            owner = OWN_VID;
        end else if (cpu_req && cpu_starved) begin
            owner = OWN_CPU;
        end else if (dsk_req) begin
            owner = OWN_DSK;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one SDRAM word port between CPU, video fetch and disk copy, one transaction at a time.
// Optional memory-ack timeout is enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W       = 25,
    parameter int DATA_W       = 16,
    parameter int CPU_MAX_SKIP = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_wtbt,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_dout,
    output logic              vid_ack,
    input  logic              dsk_req,
    input  logic              dsk_we,
    input  logic [ADDR_W-1:0] dsk_addr,
    input  logic [DATA_W-1:0] dsk_din,
    output logic [DATA_W-1:0] dsk_dout,
    output logic              dsk_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_wtbt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ack,
    output logic [1:0]        owner,
    output logic              tmo_err
);

    localparam int SKIP_W = $clog2(CPU_MAX_SKIP + 1);

    state_t            state;
    logic [SKIP_W-1:0] skip_cnt;
    logic              cpu_starved;
    owner_t            pick;
    logic              tmo_hit;
    logic              fin;
    logic              fin_load;
    logic [DATA_W-1:0] fin_data;

    assign cpu_starved = (skip_cnt >= SKIP_W'(CPU_MAX_SKIP));

    ram_arb_pick u_pick (
        .cpu_req     (cpu_req),
        .vid_req     (vid_req),
        .dsk_req     (dsk_req),
        .cpu_starved (cpu_starved),
        .owner       (pick)
    );

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Expiry fires on the edge closing the TIMEOUT_CYC-th WAIT cycle; a coincident mem_ack wins.
    assign tmo_hit = (state == ST_WAIT) && !mem_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign tmo_hit        = 1'b0;
`endif

    assign fin      = (state == ST_WAIT) && (mem_ack || tmo_hit);
    assign fin_data = mem_ack ? mem_dout : DATA_W'(TMO_DATA);
    assign fin_load = tmo_hit || !mem_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
            owner    <= OWN_NONE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_wtbt <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            cpu_dout <= '0;
            vid_dout <= '0;
            dsk_dout <= '0;
            cpu_ack  <= 1'b0;
            vid_ack  <= 1'b0;
            dsk_ack  <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            dsk_ack <= 1'b0;
            tmo_err <= 1'b0;

            // Skip count tracks consecutive non-CPU grants made while the CPU is waiting.
            if (!cpu_req) begin
                skip_cnt <= '0;
            end else if (state == ST_IDLE && pick != OWN_NONE) begin
                if (pick == OWN_CPU) begin
                    skip_cnt <= '0;
                end else if (!cpu_starved) begin
                    skip_cnt <= skip_cnt + SKIP_W'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (pick != OWN_NONE) begin
                        owner   <= pick;
                        mem_req <= 1'b1;
                        state   <= ST_WAIT;
                        case (pick)
                            OWN_CPU: begin
                                mem_we   <= cpu_we;
                                mem_wtbt <= cpu_we ? cpu_wtbt : WTBT_WORD;
                                mem_addr <= cpu_addr;
                                mem_din  <= cpu_din;
                            end
                            OWN_VID: begin
                                mem_we   <= 1'b0;
                                mem_wtbt <= WTBT_WORD;
                                mem_addr <= vid_addr;
                                mem_din  <= '0;
                            end
                            default: begin
                                mem_we   <= dsk_we;
                                mem_wtbt <= WTBT_WORD;
                                mem_addr <= dsk_addr;
                                mem_din  <= dsk_din;
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (fin) begin
                        mem_req <= 1'b0;
                        owner   <= OWN_NONE;
                        tmo_err <= tmo_hit;
                        state   <= ST_DONE;
                        case (owner)
                            OWN_CPU: begin
                                cpu_ack <= 1'b1;
                                if (fin_load) cpu_dout <= fin_data;
                            end
                            OWN_VID: begin
                                vid_ack <= 1'b1;
                                if (fin_load) vid_dout <= fin_data;
                            end
                            OWN_DSK: begin
                                dsk_ack <= 1'b1;
                                if (fin_load) dsk_dout <= fin_data;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: table of single transactions plus arbitration, reset and timeout sequences.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [1:0]  cpu_wtbt;
    logic [24:0] cpu_addr;
    logic [15:0] cpu_din, cpu_dout;
    logic        cpu_ack;
    logic        vid_req;
    logic [24:0] vid_addr;
    logic [15:0] vid_dout;
    logic        vid_ack;
    logic        dsk_req, dsk_we;
    logic [24:0] dsk_addr;
    logic [15:0] dsk_din, dsk_dout;
    logic        dsk_ack;
    logic        mem_req, mem_we;
    logic [1:0]  mem_wtbt;
    logic [24:0] mem_addr;
    logic [15:0] mem_din, mem_dout;
    logic        mem_ack;
    logic [1:0]  owner;
    logic        tmo_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .ADDR_W       (25),
        .DATA_W       (16),
        .CPU_MAX_SKIP (4),
        .TIMEOUT_CYC  (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_wtbt (cpu_wtbt),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_ack  (cpu_ack),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_dout (vid_dout),
        .vid_ack  (vid_ack),
        .dsk_req  (dsk_req),
        .dsk_we   (dsk_we),
        .dsk_addr (dsk_addr),
        .dsk_din  (dsk_din),
        .dsk_dout (dsk_dout),
        .dsk_ack  (dsk_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_wtbt (mem_wtbt),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_ack  (mem_ack),
        .owner    (owner),
        .tmo_err  (tmo_err)
    );

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [1:0]  cpu_wtbt;
        logic [24:0] cpu_addr;
        logic [15:0] cpu_din;
        logic        vid_req;
        logic [24:0] vid_addr;
        logic        dsk_req;
        logic        dsk_we;
        logic [24:0] dsk_addr;
        logic [15:0] dsk_din;
        logic [15:0] mem_rdata;
        int          ack_delay;
        logic [1:0]  exp_owner;
        logic        exp_we;
        logic [1:0]  exp_wtbt;
        logic [24:0] exp_addr;
        logic [15:0] exp_din;
        logic [15:0] exp_cpu_dout;
        logic [15:0] exp_vid_dout;
        logic [15:0] exp_dsk_dout;
    } vec_t;

    vec_t vecs[7];

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [2:0] ackFor(input logic [1:0] who);
        case (who)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic applyStimulus(input vec_t v);
        cpu_req  = v.cpu_req;
        cpu_we   = v.cpu_we;
        cpu_wtbt = v.cpu_wtbt;
        cpu_addr = v.cpu_addr;
        cpu_din  = v.cpu_din;
        vid_req  = v.vid_req;
        vid_addr = v.vid_addr;
        dsk_req  = v.dsk_req;
        dsk_we   = v.dsk_we;
        dsk_addr = v.dsk_addr;
        dsk_din  = v.dsk_din;
    endtask

    task automatic runVector(input int idx, input vec_t v);
        applyStimulus(v);
        step;
        checkOutput($sformatf("v%0d mem_req", idx), mem_req, 1'b1);
        checkOutput($sformatf("v%0d owner", idx), owner, v.exp_owner);
        checkOutput($sformatf("v%0d mem_we", idx), mem_we, v.exp_we);
        checkOutput($sformatf("v%0d mem_wtbt", idx), mem_wtbt, v.exp_wtbt);
        checkOutput($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_addr);
        checkOutput($sformatf("v%0d mem_din", idx), mem_din, v.exp_din);
        cpu_req = 1'b0;
        vid_req = 1'b0;
        dsk_req = 1'b0;
        for (int i = 0; i < v.ack_delay; i++) begin
            step;
            checkOutput($sformatf("v%0d hold mem_req", idx), mem_req, 1'b1);
            checkOutput($sformatf("v%0d hold mem_addr", idx), mem_addr, v.exp_addr);
        end
        mem_ack  = 1'b1;
        mem_dout = v.mem_rdata;
        step;
        mem_ack  = 1'b0;
        checkOutput($sformatf("v%0d acks", idx), {cpu_ack, vid_ack, dsk_ack}, ackFor(v.exp_owner));
        checkOutput($sformatf("v%0d mem_req drop", idx), mem_req, 1'b0);
        checkOutput($sformatf("v%0d cpu_dout", idx), cpu_dout, v.exp_cpu_dout);
        checkOutput($sformatf("v%0d vid_dout", idx), vid_dout, v.exp_vid_dout);
        checkOutput($sformatf("v%0d dsk_dout", idx), dsk_dout, v.exp_dsk_dout);
        step;
        checkOutput($sformatf("v%0d ack pulse", idx), {cpu_ack, vid_ack, dsk_ack}, 3'b000);
        checkOutput($sformatf("v%0d owner idle", idx), owner, OWN_NONE);
    endtask

    // Waits for a grant, acks it with rdata, checks the ack and releases that requester unless told to keep disk.
    task automatic serve(input logic [15:0] rdata, input bit keep_dsk, output logic [1:0] who);
        int n = 0;
        while (!mem_req && n < 20) begin
            step;
            n++;
        end
        if (!mem_req) begin
            checkOutput("grant wait", 32'd0, 32'd1);
            who = OWN_NONE;
            return;
        end
        who      = owner;
        mem_ack  = 1'b1;
        mem_dout = rdata;
        step;
        mem_ack  = 1'b0;
        checkOutput("serve ack", {cpu_ack, vid_ack, dsk_ack}, ackFor(who));
        case (who)
            2'd1:    cpu_req = 1'b0;
            2'd2:    vid_req = 1'b0;
            2'd3:    if (!keep_dsk) dsk_req = 1'b0;
            default: ;
        endcase
        step;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [1:0] who;
        logic [1:0] order[3];
        logic [1:0] exp_order[3];
        logic [1:0] starve_exp[6];
        logic       seen_ack;

        vecs[0] = '{1'b1, 1'b0, 2'b00, 25'h0000100, 16'h0000, 1'b0, 25'h0, 1'b0, 1'b0, 25'h0, 16'h0,
                    16'h1234, 2, OWN_CPU, 1'b0, 2'b11, 25'h0000100, 16'h0000, 16'h1234, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 2'b10, 25'h0004000, 16'hABCD, 1'b0, 25'h0, 1'b0, 1'b0, 25'h0, 16'h0,
                    16'h5555, 1, OWN_CPU, 1'b1, 2'b10, 25'h0004000, 16'hABCD, 16'h1234, 16'h0000, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 2'b00, 25'h0, 16'h0, 1'b1, 25'h1FFFFFF, 1'b0, 1'b0, 25'h0, 16'h0,
                    16'hBEEF, 0, OWN_VID, 1'b0, 2'b11, 25'h1FFFFFF, 16'h0000, 16'h1234, 16'hBEEF, 16'h0000};
        vecs[3] = '{1'b0, 1'b0, 2'b00, 25'h0, 16'h0, 1'b0, 25'h0, 1'b1, 1'b1, 25'h0000000, 16'h0F0F,
                    16'h7777, 3, OWN_DSK, 1'b1, 2'b11, 25'h0000000, 16'h0F0F, 16'h1234, 16'hBEEF, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 2'b00, 25'h0, 16'h0, 1'b0, 25'h0, 1'b1, 1'b0, 25'h1234567, 16'h9999,
                    16'hCAFE, 0, OWN_DSK, 1'b0, 2'b11, 25'h1234567, 16'h9999, 16'h1234, 16'hBEEF, 16'hCAFE};
        vecs[5] = '{1'b1, 1'b1, 2'b01, 25'h0000001, 16'h00FF, 1'b0, 25'h0, 1'b0, 1'b0, 25'h0, 16'h0,
                    16'h6666, 0, OWN_CPU, 1'b1, 2'b01, 25'h0000001, 16'h00FF, 16'h1234, 16'hBEEF, 16'hCAFE};
        vecs[6] = '{1'b1, 1'b0, 2'b01, 25'h0ABCDEF, 16'h0000, 1'b0, 25'h0, 1'b0, 1'b0, 25'h0, 16'h0,
                    16'h8001, 1, OWN_CPU, 1'b0, 2'b11, 25'h0ABCDEF, 16'h0000, 16'h8001, 16'hBEEF, 16'hCAFE};

        reset_n  = 1'b0;
        cpu_req  = 1'b0; cpu_we = 1'b0; cpu_wtbt = 2'b00; cpu_addr = '0; cpu_din = '0;
        vid_req  = 1'b0; vid_addr = '0;
        dsk_req  = 1'b0; dsk_we = 1'b0; dsk_addr = '0; dsk_din = '0;
        mem_dout = '0;   mem_ack = 1'b0;

        step;
        step;
        checkOutput("reset mem_req", mem_req, 1'b0);
        checkOutput("reset owner", owner, OWN_NONE);
        checkOutput("reset acks", {cpu_ack, vid_ack, dsk_ack, tmo_err}, 4'b0000);
        checkOutput("reset mem_bus", {mem_we, mem_wtbt, mem_addr, mem_din}, 32'd0);
        checkOutput("reset douts", {cpu_dout, vid_dout}, 32'd0);
        checkOutput("reset dsk_dout", dsk_dout, 16'h0000);
        reset_n = 1'b1;
        step;

        for (int i = 0; i < 7; i++) begin
            runVector(i, vecs[i]);
        end

        $display("[TB] simultaneous requests");
        exp_order[0] = OWN_VID; exp_order[1] = OWN_DSK; exp_order[2] = OWN_CPU;
        cpu_we = 1'b0; dsk_we = 1'b0; vid_addr = 25'h10; dsk_addr = 25'h20; cpu_addr = 25'h30;
        cpu_req = 1'b1; vid_req = 1'b1; dsk_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serve(16'h1000 + 16'(i), 1'b0, order[i]);
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("order %0d", i), order[i], exp_order[i]);
        end
        checkOutput("order vid_dout", vid_dout, 16'h1000);
        checkOutput("order dsk_dout", dsk_dout, 16'h1001);
        checkOutput("order cpu_dout", cpu_dout, 16'h1002);

        $display("[TB] cpu starvation bound");
        starve_exp[0] = OWN_DSK; starve_exp[1] = OWN_DSK; starve_exp[2] = OWN_DSK;
        starve_exp[3] = OWN_DSK; starve_exp[4] = OWN_CPU; starve_exp[5] = OWN_DSK;
        cpu_req = 1'b1; dsk_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            serve(16'h2000, (i < 5), who);
            checkOutput($sformatf("starve grant %0d", i), who, starve_exp[i]);
        end
        cpu_req = 1'b0; dsk_req = 1'b0;
        step;

        $display("[TB] reset during wait");
        dsk_we = 1'b0; dsk_addr = 25'h0000300; dsk_req = 1'b1;
        step;
        checkOutput("rst pre mem_req", mem_req, 1'b1);
        dsk_req = 1'b0;
        step;
        reset_n = 1'b0;
        #1;
        checkOutput("rst async mem_req", mem_req, 1'b0);
        checkOutput("rst async owner", owner, OWN_NONE);
        @(negedge clk);
        checkOutput("rst no ack", {cpu_ack, vid_ack, dsk_ack}, 3'b000);
        reset_n = 1'b1;
        step;
        checkOutput("rst idle mem_req", mem_req, 1'b0);
        vid_addr = 25'h0000042; vid_req = 1'b1;
        serve(16'h4242, 1'b0, who);
        checkOutput("rst vid owner", who, OWN_VID);
        checkOutput("rst vid_dout", vid_dout, 16'h4242);
        checkOutput("rst dsk_dout cleared", dsk_dout, 16'h0000);

        $display("[TB] slow memory");
        dsk_we = 1'b0; dsk_addr = 25'h0000200; dsk_req = 1'b1;
        step;
        dsk_req  = 1'b0;
        seen_ack = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            step;
            seen_ack |= dsk_ack | tmo_err;
        end
        checkOutput("tmo early ack", seen_ack, 1'b0);
        checkOutput("tmo hold mem_req", mem_req, 1'b1);
        step;
        checkOutput("tmo dsk_ack", dsk_ack, 1'b1);
        checkOutput("tmo err", tmo_err, 1'b1);
        checkOutput("tmo dsk_dout", dsk_dout, 16'hFFFF);
        checkOutput("tmo mem_req drop", mem_req, 1'b0);
        step;
        checkOutput("tmo pulse", {dsk_ack, tmo_err}, 2'b00);
        dsk_req = 1'b1;
        step;
        dsk_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step;
        end
        mem_ack  = 1'b1;
        mem_dout = 16'h2468;
`else
        for (int i = 0; i < 20; i++) begin
            step;
            seen_ack |= dsk_ack | tmo_err;
        end
        checkOutput("slow no ack", seen_ack, 1'b0);
        checkOutput("slow hold mem_req", mem_req, 1'b1);
        checkOutput("slow hold addr", mem_addr, 25'h0000200);
        mem_ack  = 1'b1;
        mem_dout = 16'h2468;
`endif
        step;
        mem_ack = 1'b0;
        checkOutput("late dsk_ack", dsk_ack, 1'b1);
        checkOutput("late tmo_err", tmo_err, 1'b0);
        checkOutput("late dsk_dout", dsk_dout, 16'h2468);
        step;
        step;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
